// File: rtl/ps2_frame_rx_pkg.sv
// Shared types and constants for the PS/2 frame receiver.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_e;

   localparam logic [7:0] PS2_BREAK  = 8'hF0;
   localparam logic [7:0] PS2_EXTEND = 8'hE0;

   localparam int unsigned PS2_FILTER_LEN_DEF     = 8;
   localparam int unsigned PS2_TIMEOUT_CYCLES_DEF = 65000;

   // Prefix bytes extend a scancode rather than complete one.
   function automatic logic is_prefix(input logic [7:0] b);
      return (b == PS2_BREAK) || (b == PS2_EXTEND);
   endfunction

endpackage

// File: rtl/ps2_frame_rx_if.sv
// PS/2 line inputs and decoded-byte outputs of the frame receiver.
interface ps2_frame_rx_if;
   logic        ps2_clk;
   logic        ps2_data;
   logic [7:0]  rx_byte;
   logic        byte_valid;
   logic [15:0] keycode;
   logic        oflag;
   logic        parity_err;
   logic        frame_err;

   modport master (
      output ps2_clk, ps2_data,
      input  rx_byte, byte_valid, keycode, oflag, parity_err, frame_err
   );

   modport slave (
      input  ps2_clk, ps2_data,
      output rx_byte, byte_valid, keycode, oflag, parity_err, frame_err
   );
endinterface

// File: rtl/ps2_frame_rx_input_filter.sv
// Synchronises the raw PS/2 lines, glitch-filters the clock and flags its
// falling edges; data is only synchronised.
module ps2_input_filter
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN = PS2_FILTER_LEN_DEF
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic ps2_clk_i,
   input  logic ps2_data_i,
   output logic fall_o,
   output logic data_o
);

   localparam int unsigned CNT_W = $clog2(FILTER_LEN) + 1;

   logic [1:0]       clk_sync_q;
   logic [1:0]       dat_sync_q;
   logic             filt_q, filt_d;
   logic             filt_prev_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counts consecutive synced samples that disagree with the filtered level.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (clk_sync_q[1] != filt_q) begin
         if (cnt_q == CNT_W'(FILTER_LEN - 1))
            filt_d = clk_sync_q[1];
         else
            cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         clk_sync_q  <= 2'b11;
         dat_sync_q  <= 2'b11;
         filt_q      <= 1'b1;
         filt_prev_q <= 1'b1;
         cnt_q       <= '0;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
         dat_sync_q  <= {dat_sync_q[0], ps2_data_i};
         filt_q      <= filt_d;
         filt_prev_q <= filt_q;
         cnt_q       <= cnt_d;
      end
   end

   assign fall_o = filt_prev_q & ~filt_q;
   assign data_o = dat_sync_q[1];

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host deframer with rolling 16-bit keycode.
// Optional mid-frame timeout enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN     = PS2_FILTER_LEN_DEF,
   parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEF
) (
   input  logic          clk,
   input  logic          rst,
   ps2_frame_rx_if.slave bus
);

   logic fall;
   logic data_s;

   ps2_input_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_filter (
      .clk_i      (clk),
      .rst_n_i    (rst),
      .ps2_clk_i  (bus.ps2_clk),
      .ps2_data_i (bus.ps2_data),
      .fall_o     (fall),
      .data_o     (data_s)
   );

   ps2_state_e  state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        par_q, par_d;
   logic        timeout;

   logic        deliver_d, perr_d, ferr_d;
   logic [7:0]  rx_byte_q;
   logic [15:0] keycode_q;
   logic        byte_valid_q, oflag_q, perr_q, ferr_q;

`ifdef PS2_RX_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;

   assign timeout = (state_q != IDLE) && !fall &&
                    (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      to_cnt_d = to_cnt_q + 1'b1;
      if (fall || (state_q == IDLE) || timeout)
         to_cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) to_cnt_q <= '0;
      else      to_cnt_q <= to_cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
      end
   end

   // Bits arrive LSB first, so each new bit enters at the top.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      if (timeout) begin
         state_d = IDLE;
      end else if (fall) begin
         case (state_q)
            IDLE: begin
               if (!data_s) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end
            end
            DATA: begin
               shift_d   = {data_s, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               par_d   = data_s;
               state_d = STOP;
            end
            STOP:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      deliver_d = 1'b0;
      perr_d    = 1'b0;
      ferr_d    = 1'b0;
      if (timeout) begin
         ferr_d = 1'b1;
      end else if (fall) begin
         case (state_q)
            IDLE: ferr_d = data_s;
            STOP: begin
               if (!data_s)                  ferr_d    = 1'b1;
               else if (^{shift_q, par_q})   deliver_d = 1'b1;
               else                          perr_d    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Results register here, one cycle after the deciding fall.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_byte_q    <= '0;
         keycode_q    <= '0;
         byte_valid_q <= 1'b0;
         oflag_q      <= 1'b0;
         perr_q       <= 1'b0;
         ferr_q       <= 1'b0;
      end else begin
         byte_valid_q <= deliver_d;
         oflag_q      <= deliver_d && !is_prefix(shift_q);
         perr_q       <= perr_d;
         ferr_q       <= ferr_d;
         if (deliver_d) begin
            rx_byte_q <= shift_q;
            keycode_q <= {keycode_q[7:0], shift_q};
         end
      end
   end

   assign bus.rx_byte    = rx_byte_q;
   assign bus.keycode    = keycode_q;
   assign bus.byte_valid = byte_valid_q;
   assign bus.oflag      = oflag_q;
   assign bus.parity_err = perr_q;
   assign bus.frame_err  = ferr_q;

endmodule
